// File: rtl/pce_audio_mixer_mc_pkg.sv
// pce_audio_pkg: shared types and constants for the PCE audio mixer.
// Holds the mixer FSM states, gain shift, compressor knees and sat().
package pce_audio_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_OUT
  } mix_state_t;

  localparam int GAIN_UNITY_SHIFT = 6;

  localparam int COMP1_A = 2;
  localparam int COMP1_F = 4;
  localparam int COMP2_A = 4;
  localparam int COMP2_F = 8;

  // Clamp v into the signed range of a w-bit sample.
  function automatic logic signed [31:0] sat(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pce_audio_mixer_mc_if.sv
// Mixer bus: sample_ce/channel inputs towards the mixer, mixed audio back.
// master = audio source side, slave = pce_audio_mixer_mc.
interface pce_audio_mixer_mc_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8
);
  logic                     sample_ce;
  logic [NUM_CH*IN_W-1:0]   ch_l;
  logic [NUM_CH*IN_W-1:0]   ch_r;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [NUM_CH-1:0]        ch_mute;
  logic [1:0]               master_boost;
  logic signed [IN_W-1:0]   audio_l;
  logic signed [IN_W-1:0]   audio_r;
  logic                     audio_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output sample_ce, ch_l, ch_r,
    output ch_gain, ch_mute, master_boost,
    input  audio_l, audio_r,
    input  audio_valid, busy, overrun
  );

  modport slave (
    input  sample_ce, ch_l, ch_r,
    input  ch_gain, ch_mute, master_boost,
    output audio_l, audio_r,
    output audio_valid, busy, overrun
  );
endinterface

// File: rtl/pce_audio_mixer_mc_compressor.sv
// pce_audio_compressor: combinational soft knee on a saturated sample.
// Ports: s_i sample in, boost_i knee select (0 = bypass), y_o sample out.
module pce_audio_compressor
  import pce_audio_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0] s_i,
  input  logic [1:0]             boost_i,
  output logic signed [IN_W-1:0] y_o
);

  localparam int MAXV = (1 << (IN_W - 1)) - 1;

  int   a;
  int   f;
  int   m;
  int   x;
  int   r;
  logic byp;

  always_comb begin
    a   = COMP1_A;
    f   = COMP1_F;
    byp = 1'b0;
    unique case (boost_i)
      2'd0: byp = 1'b1;
      2'd1: begin
        a = COMP1_A;
        f = COMP1_F;
      end
      default: begin
        a = COMP2_A;
        f = COMP2_F;
      end
    endcase
    m = int'(s_i);
    if (m < 0) m = -m;
    if (m > MAXV) m = MAXV;
    x = (MAXV * (f - 1)) / (f * a - 1) + 1;
    r = (m < x) ? m * a : (m - x) / f + a * x;
    // The knee rounding can land one past full scale.
    if (r > MAXV) r = MAXV;
    if (byp)
      y_o = s_i;
    else if (s_i < 0)
      y_o = IN_W'(-r);
    else
      y_o = IN_W'(r);
  end

endmodule

// File: rtl/pce_audio_mixer_mc.sv
// pce_audio_mixer_mc: N-channel stereo gain/mute mixer, one MAC per cycle.
// clk/reset_n plain; mix_if slave carries samples in, audio/valid/busy/overrun out. Compressor: PCE_AUDIO_MIX_COMPRESSOR_EN.
module pce_audio_mixer_mc
  import pce_audio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8
) (
  input logic                clk_sys_42_95,
  input logic                reset_n,
  pce_audio_mixer_mc_if.slave mix_if
);

  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mix_state_t               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [NUM_CH*IN_W-1:0]   snap_l_q;
  logic [NUM_CH*IN_W-1:0]   snap_r_q;
  logic [NUM_CH*GAIN_W-1:0] snap_g_q;
  logic [NUM_CH-1:0]        snap_m_q;
  logic signed [ACC_W-1:0]  acc_l_q;
  logic signed [ACC_W-1:0]  acc_r_q;
  logic signed [IN_W-1:0]   sat_l_q;
  logic signed [IN_W-1:0]   sat_r_q;
  logic signed [IN_W-1:0]   audio_l_q;
  logic signed [IN_W-1:0]   audio_r_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic signed [IN_W-1:0]   sl;
  logic signed [IN_W-1:0]   sr;
  logic signed [GAIN_W:0]   g;
  logic signed [PROD_W-1:0] pl;
  logic signed [PROD_W-1:0] pr;
  logic signed [ACC_W-1:0]  acc_l_d;
  logic signed [ACC_W-1:0]  acc_r_d;
  logic signed [IN_W-1:0]   sat_l_d;
  logic signed [IN_W-1:0]   sat_r_d;
  logic signed [IN_W-1:0]   out_l;
  logic signed [IN_W-1:0]   out_r;

  always_comb begin
    sl = snap_l_q[idx_q*IN_W +: IN_W];
    sr = snap_r_q[idx_q*IN_W +: IN_W];
    // Gain is unsigned: zero-extend before the signed multiply.
    g  = {1'b0, snap_g_q[idx_q*GAIN_W +: GAIN_W]};
    pl = PROD_W'(sl) * PROD_W'(g);
    pr = PROD_W'(sr) * PROD_W'(g);
    if (snap_m_q[idx_q]) begin
      pl = '0;
      pr = '0;
    end
    acc_l_d = acc_l_q + ACC_W'(pl);
    acc_r_d = acc_r_q + ACC_W'(pr);
    sat_l_d = IN_W'(sat(32'(acc_l_q >>> GAIN_UNITY_SHIFT), IN_W));
    sat_r_d = IN_W'(sat(32'(acc_r_q >>> GAIN_UNITY_SHIFT), IN_W));
  end

`ifdef PCE_AUDIO_MIX_COMPRESSOR_EN
  pce_audio_compressor #(.IN_W(IN_W)) u_comp_l (
    .s_i     (sat_l_q),
    .boost_i (mix_if.master_boost),
    .y_o     (out_l)
  );
  pce_audio_compressor #(.IN_W(IN_W)) u_comp_r (
    .s_i     (sat_r_q),
    .boost_i (mix_if.master_boost),
    .y_o     (out_r)
  );
`else
  logic unused_boost;
  assign unused_boost = ^mix_if.master_boost;
  assign out_l = sat_l_q;
  assign out_r = sat_r_q;
`endif

  always_ff @(posedge clk_sys_42_95 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      snap_l_q  <= '0;
      snap_r_q  <= '0;
      snap_g_q  <= '0;
      snap_m_q  <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      sat_l_q   <= '0;
      sat_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (mix_if.sample_ce && state_q != S_IDLE)
        overrun_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (mix_if.sample_ce) begin
            snap_l_q <= mix_if.ch_l;
            snap_r_q <= mix_if.ch_r;
            snap_g_q <= mix_if.ch_gain;
            snap_m_q <= mix_if.ch_mute;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          if (idx_q == IDX_W'(NUM_CH - 1))
            state_q <= S_SCALE;
          else
            idx_q <= idx_q + IDX_W'(1);
        end
        S_SCALE: begin
          sat_l_q <= sat_l_d;
          sat_r_q <= sat_r_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          audio_l_q <= out_l;
          audio_r_q <= out_r;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mix_if.audio_l     = audio_l_q;
  assign mix_if.audio_r     = audio_r_q;
  assign mix_if.audio_valid = valid_q;
  assign mix_if.busy        = busy_q;
  assign mix_if.overrun     = overrun_q;

endmodule

// File: tb/tb_pce_audio_mixer_mc.sv
// Bench for pce_audio_mixer_mc: vector table, random mixes vs model,
// overrun/snapshot, reset-abort and (if enabled) compressor sequences.
module tb_pce_audio_mixer_mc;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int GAIN_W = 8;
  localparam int LAT    = NUM_CH + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pce_audio_mixer_mc_if #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W)
  ) mif ();

  pce_audio_mixer_mc #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W)
  ) dut (
    .clk_sys_42_95 (clk),
    .reset_n       (rst_n),
    .mix_if        (mif)
  );

  typedef struct packed {
    logic [3:0][15:0] l;
    logic [3:0][15:0] r;
    logic [3:0][7:0]  g;
    logic [3:0]       m;
    logic [1:0]       boost;
    logic signed [31:0] exp_l;
    logic signed [31:0] exp_r;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] rep16(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic logic [3:0][7:0] rep8(input logic [7:0] v);
    return {4{v}};
  endfunction

  // Sum of sample*gain over unmuted channels, floor(/64), clamp.
  function automatic longint model_mix(input logic [3:0][15:0] s,
                                       input logic [3:0][7:0] g,
                                       input logic [3:0] m);
    longint sum;
    longint q;
    sum = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (!m[k])
        sum += longint'($signed(s[k])) * longint'(g[k]);
    q = sum / 64;
    if ((sum % 64) != 0 && sum < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

`ifdef PCE_AUDIO_MIX_COMPRESSOR_EN
  function automatic longint model_comp(input longint s,
                                        input logic [1:0] b);
    longint a, f, m, x, r;
    if (b == 2'd0) return s;
    a = (b == 2'd1) ? 2 : 4;
    f = (b == 2'd1) ? 4 : 8;
    m = (s < 0) ? -s : s;
    if (m > 32767) m = 32767;
    x = (32767 * (f - 1)) / (f * a - 1) + 1;
    r = (m < x) ? m * a : (m - x) / f + a * x;
    if (r > 32767) r = 32767;
    return (s < 0) ? -r : r;
  endfunction
`endif

  task automatic drive(input vec_t v);
    mif.ch_l         = v.l;
    mif.ch_r         = v.r;
    mif.ch_gain      = v.g;
    mif.ch_mute      = v.m;
    mif.master_boost = v.boost;
  endtask

  task automatic run_mix(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    drive(v);
    mif.sample_ce = 1'b1;
    @(posedge clk);
    #1 mif.sample_ce = 1'b0;
    chk({nm, ".busy"}, longint'(mif.busy), 1);
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (mif.audio_valid) lat = n;
    end
    chk({nm, ".lat"}, lat, LAT);
    chk({nm, ".l"}, longint'(mif.audio_l), longint'(v.exp_l));
    chk({nm, ".r"}, longint'(mif.audio_r), longint'(v.exp_r));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".l"}, longint'(mif.audio_l), 0);
    chk({nm, ".r"}, longint'(mif.audio_r), 0);
    chk({nm, ".valid"}, longint'(mif.audio_valid), 0);
    chk({nm, ".busy"}, longint'(mif.busy), 0);
    chk({nm, ".ovr"}, longint'(mif.overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   pulses;
    int   first;
    longint cap_l;
    longint cap_r;
    longint sl;
    longint sr;

    for (int i = 0; i < 8; i++) tbl[i] = '0;
    tbl[0].l = rep16(16'd30000); tbl[0].l[0] = 16'd1000;
    tbl[0].r = rep16(16'd30000); tbl[0].r[0] = 16'(-500);
    tbl[0].g = rep8(8'd255);     tbl[0].g[0] = 8'd64;
    tbl[0].m = 4'b1110;
    tbl[0].exp_l = 1000;  tbl[0].exp_r = -500;
    tbl[1].l = rep16(16'd20000); tbl[1].g = rep8(8'd64);
    tbl[1].exp_l = 32767; tbl[1].exp_r = 0;
    tbl[2].l = rep16(16'(-20000)); tbl[2].r = rep16(16'd1000);
    tbl[2].g = rep8(8'd64);
    tbl[2].exp_l = -32768; tbl[2].exp_r = 4000;
    tbl[3].l = rep16(16'd9999); tbl[3].l[0] = 16'(-3);
    tbl[3].r = rep16(16'd9999); tbl[3].r[0] = 16'd3;
    tbl[3].g = rep8(8'd200);    tbl[3].g[0] = 8'd32;
    tbl[3].m = 4'b1110;
    tbl[3].exp_l = -2; tbl[3].exp_r = 1;
    tbl[4].l = rep16(16'd9999); tbl[4].l[1] = 16'd100;
    tbl[4].r = rep16(16'd9999); tbl[4].r[1] = 16'(-100);
    tbl[4].g = rep8(8'd200);    tbl[4].g[1] = 8'd255;
    tbl[4].m = 4'b1101;
    tbl[4].exp_l = 398; tbl[4].exp_r = -399;
    tbl[5].l = rep16(16'd12345); tbl[5].r = rep16(16'(-12345));
    tbl[5].exp_l = 0; tbl[5].exp_r = 0;
    tbl[6].l = rep16(16'd30000); tbl[6].r = rep16(16'(-30000));
    tbl[6].g = rep8(8'd255); tbl[6].m = 4'b1111;
    tbl[6].exp_l = 0; tbl[6].exp_r = 0;
    tbl[7].l[0] = 16'h7FFF; tbl[7].l[1] = 16'h8000;
    tbl[7].l[2] = 16'hFFFF; tbl[7].l[3] = 16'd0;
    tbl[7].g = rep8(8'd255); tbl[7].g[2] = 8'd1;
    tbl[7].r = rep16(16'h8000);
    tbl[7].exp_l = -4; tbl[7].exp_r = -32768;

    mif.sample_ce = 1'b0;
    drive(tbl[1]);
    repeat (2) @(posedge clk);
    #1 chk_idle("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle("rst_rel");

    for (int i = 0; i < 8; i++)
      run_mix(tbl[i], $sformatf("tbl%0d", i));
    chk("b2b.ovr", longint'(mif.overrun), 0);

    for (int i = 0; i < 40; i++) begin
      v = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        v.l[k] = 16'($urandom);
        v.r[k] = 16'($urandom);
        v.g[k] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) v.m = 4'($urandom);
      v.boost = 2'($urandom);
      sl = model_mix(v.l, v.g, v.m);
      sr = model_mix(v.r, v.g, v.m);
`ifdef PCE_AUDIO_MIX_COMPRESSOR_EN
      sl = model_comp(sl, v.boost);
      sr = model_comp(sr, v.boost);
`endif
      v.exp_l = 32'(sl);
      v.exp_r = 32'(sr);
      run_mix(v, $sformatf("rnd%0d", i));
    end
    chk("rnd.ovr", longint'(mif.overrun), 0);

    // Second sample_ce two edges in; inputs also change after E.
    @(negedge clk);
    drive(tbl[0]);
    mif.sample_ce = 1'b1;
    @(posedge clk);
    #1 mif.sample_ce = 1'b0;
    mif.ch_l = rep16(16'd7777);
    mif.ch_mute = 4'b0000;
    @(posedge clk);
    @(negedge clk) mif.sample_ce = 1'b1;
    @(posedge clk);
    #1 mif.sample_ce = 1'b0;
    chk("ovr.set", longint'(mif.overrun), 1);
    pulses = 0;
    first = -1;
    cap_l = 0;
    cap_r = 0;
    for (int n = 3; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (mif.audio_valid) begin
        pulses++;
        if (first < 0) begin
          first = n;
          cap_l = longint'(mif.audio_l);
          cap_r = longint'(mif.audio_r);
        end
      end
    end
    chk("ovr.pulses", pulses, 1);
    chk("ovr.lat", first, LAT);
    chk("ovr.l", cap_l, 1000);
    chk("ovr.r", cap_r, -500);

    run_mix(tbl[0], "sticky");
    chk("sticky.ovr", longint'(mif.overrun), 1);

    // Reset in the middle of ACCUM aborts the mix.
    @(negedge clk);
    drive(tbl[4]);
    mif.sample_ce = 1'b1;
    @(posedge clk);
    #1 mif.sample_ce = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle("abort");
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (mif.audio_valid) pulses++;
    end
    chk("abort.pulses", pulses, 0);
    chk("abort.busy", longint'(mif.busy), 0);
    run_mix(tbl[0], "post_abort");

    v = '0;
    v.l[0] = 16'd4000; v.r[0] = 16'(-4000);
    v.g[0] = 8'd64; v.m = 4'b1110; v.boost = 2'd1;
`ifdef PCE_AUDIO_MIX_COMPRESSOR_EN
    v.exp_l = 8000; v.exp_r = -8000;
    run_mix(v, "comp1");
    v.boost = 2'd2;
    v.exp_l = 16000; v.exp_r = -16000;
    run_mix(v, "comp2");
    v.boost = 2'd1;
    v.l[0] = 16'd32767; v.r[0] = 16'h8000;
    v.exp_l = 32767; v.exp_r = -32767;
    run_mix(v, "comp_full");
    v.boost = 2'd0;
    v.l[0] = 16'd4000; v.r[0] = 16'(-4000);
    v.exp_l = 4000; v.exp_r = -4000;
    run_mix(v, "comp_byp");
`else
    v.exp_l = 4000; v.exp_r = -4000;
    run_mix(v, "boost_ign");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
